main_mem_ctrl: RTL and testbench
================================

// Module: main_mem_ctrl
// PURPOSE
//  Request/response front end for the banked main-memory array (4 row chips x 2 byte-lane halves).
//  Accepts single-word read/write requests from the CPU/cache side over a valid/ready handshake.
//  Sequences cs/we/oe toward the synchronous single-port RAM array.
//  Owns the bidirectional mem_data bus and returns read data or a write acknowledge over a held response channel.
// PARAMETERS
//  ADDR_WIDTH  14  word address width; top 2 bits select the RAM row chip downstream
//  DATA_WIDTH  16  word width of the memory data bus
//  RD_LAT      1   RAM read latency in clocks (>=1); cycles cs/oe held before capture
// PORTS
//  clk        in     1           system clock, all state on rising edge
//  rst_n      in     1           asynchronous active-low reset
//  req_valid  in     1           request present
//  req_ready  out    1           controller can accept request (IDLE only)
//  req_we     in     1           1 = write, 0 = read
//  req_addr   in     ADDR_WIDTH  word address
//  req_wdata  in     DATA_WIDTH  write data
//  rsp_valid  out    1           response present (read data or write ack)
//  rsp_ready  in     1           consumer accepts response
//  rsp_we     out    1           echo of request type for this response
//  rsp_rdata  out    DATA_WIDTH  read data; 0 for write acks
//  mem_addr   out    ADDR_WIDTH  address to RAM array
//  mem_data   inout  DATA_WIDTH  RAM data bus; driven only in WR state, else 'z
//  mem_cs     out    1           chip-select enable to array decoder
//  mem_we     out    1           RAM write enable
//  mem_oe     out    1           RAM output enable
// BEHAVIOUR
//  - FSM: IDLE -> WR -> RSP, or IDLE -> RD -> RSP; RSP -> IDLE on rsp_valid&&rsp_ready.
//  - Reset (rst_n=0, async): state=IDLE, req_ready=1.
//    rsp_valid=0, rsp_we=0, rsp_rdata=0, mem_addr=0, mem_cs=0, mem_we=0, mem_oe=0, mem_data='z, rd counter=0.
//  - IDLE: req_ready=1. On req_valid&&req_ready, register addr/we/wdata.
//    Next cycle is WR (req_we=1) or RD (req_we=0). req_ready=0 in all other states.
//  - WR: exactly 1 cycle. mem_cs=1, mem_we=1, mem_oe=0, mem_data=wdata, mem_addr=addr; RAM writes at end of cycle.
//  - RD: mem_cs=1, mem_we=0, mem_oe=1, mem_data='z, for RD_LAT+1 cycles (counter 0..RD_LAT).
//    rsp_rdata <= mem_data at the edge ending the last RD cycle.
//  - RSP: mem_cs=mem_we=mem_oe=0, bus 'z. rsp_valid=1, rsp_we=latched type.
//    rsp_rdata and rsp_we stay stable until accepted.
//  - Latency with RD_LAT=1 and rsp_ready=1, counted from the accept edge:
//    write ack rsp_valid at +2 cycles; read rsp_valid at +3 cycles; next req_ready one cycle after response handshake.
//  - Outputs: registered (no combinational path from req_* or rsp_ready to mem_* or rsp_*).
//    req_ready decodes state only.
//  - No bus contention: mem_data is never driven while mem_oe=1; at least one idle/RSP cycle between RD and next WR.
//  - req inputs ignored outside IDLE; req_valid may drop without effect when not accepted.
//  - Address wrap: none; full ADDR_WIDTH passed through, top-bit row select done downstream.
//  - Reset mid-operation: abort immediately.
//    Bus released, cs/we/oe low, any pending response discarded; no partial write beyond a cycle already completed.
// TESTING
//  1. Write 0xBEEF @0x0005 then read @0x0005 -> rsp_we=1 ack (rdata 0), then rsp_rdata=0xBEEF.
//  2. Row select: write 0x1111 @0x0001, 0x2222 @0x1001, 0x3333 @0x2001, 0x4444 @0x3001;
//     read back all four -> distinct values, no aliasing.
//  3. Backpressure: read with rsp_ready=0 for 5 cycles -> rsp_valid held, rdata stable, req_ready=0; accept -> IDLE.
//  4. Bus check: monitor mem_data each cycle -> 'z whenever state!=WR; mem_we&&mem_oe never both 1.
//  5. Reset in RD (assert rst_n=0 mid-cycle) -> all outputs at reset values asynchronously; after release req_ready=1, no rsp.
//  6. Latency, RD_LAT=1 and RD_LAT=3: back-to-back reads with rsp_ready=1 -> rsp_valid at +3/+5 cycles after accept.

Source files
------------

// File: rtl/main_mem_ctrl.sv
// Request/response front end for the banked main-memory array.
// Sequences cs/we/oe toward a synchronous single-port RAM and owns the shared data bus.
module main_mem_ctrl #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 16,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_we,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe
);
  localparam int CNT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT);

  typedef enum logic [1:0] {IDLE, WR, RD, RSP} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_we_q, rsp_we_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  mem_cs_q, mem_cs_d;
  logic                  mem_we_q, mem_we_d;
  logic                  mem_oe_q, mem_oe_d;
  logic                  drv_q, drv_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wdata_d     = wdata_q;
    mem_addr_d  = mem_addr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_we_d    = rsp_we_q;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d    = req_we ? WR : RD;
          mem_addr_d = req_addr;
          wdata_d    = req_wdata;
          cnt_d      = '0;
        end
      end
      WR: begin
        state_d     = RSP;
        rsp_valid_d = 1'b1;
        rsp_we_d    = 1'b1;
        rsp_rdata_d = '0;
      end
      RD: begin
        // Capture on the edge that closes the last of RD_LAT+1 enabled cycles.
        if (cnt_q == CNT_LAST) begin
          state_d     = RSP;
          rsp_valid_d = 1'b1;
          rsp_we_d    = 1'b0;
          rsp_rdata_d = mem_data;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Strobes are decoded from the next state so they leave flops aligned with the state.
    mem_cs_d = (state_d == WR) || (state_d == RD);
    mem_we_d = (state_d == WR);
    mem_oe_d = (state_d == RD);
    drv_d    = (state_d == WR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wdata_q     <= '0;
      mem_addr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_oe_q    <= 1'b0;
      drv_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wdata_q     <= wdata_d;
      mem_addr_q  <= mem_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_we_q    <= rsp_we_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_cs_q    <= mem_cs_d;
      mem_we_q    <= mem_we_d;
      mem_oe_q    <= mem_oe_d;
      drv_q       <= drv_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_we    = rsp_we_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_cs    = mem_cs_q;
  assign mem_we    = mem_we_q;
  assign mem_oe    = mem_oe_q;
  assign mem_data  = drv_q ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Bench for main_mem_ctrl: two instances (RD_LAT=1 and RD_LAT=3) each backed by a
// behavioural RAM, checked against an address->data reference map and latency rules.
module tb_main_mem_ctrl;
  localparam int AW = 14;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic          req_valid, req_we, rsp_ready, req_ready, rsp_valid, rsp_we;
  logic          mem_cs, mem_we, mem_oe;
  logic [AW-1:0] req_addr, mem_addr;
  logic [DW-1:0] req_wdata, rsp_rdata;
  wire  [DW-1:0] mem_data;

  logic          req_valid3, req_we3, rsp_ready3, req_ready3, rsp_valid3, rsp_we3;
  logic          mem_cs3, mem_we3, mem_oe3;
  logic [AW-1:0] req_addr3, mem_addr3;
  logic [DW-1:0] req_wdata3, rsp_rdata3;
  wire  [DW-1:0] mem_data3;

  main_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_we(rsp_we), .rsp_rdata(rsp_rdata), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe));

  main_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3), .req_we(req_we3),
    .req_addr(req_addr3), .req_wdata(req_wdata3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
    .rsp_we(rsp_we3), .rsp_rdata(rsp_rdata3), .mem_addr(mem_addr3), .mem_data(mem_data3),
    .mem_cs(mem_cs3), .mem_we(mem_we3), .mem_oe(mem_oe3));

  // RAM models only present data once oe has been held for RD_LAT cycles.
  logic [DW-1:0] ram1 [0:(1<<AW)-1];
  logic [DW-1:0] ram3 [0:(1<<AW)-1];
  int oe_cnt1 = 0;
  int oe_cnt3 = 0;
  assign mem_data  = (mem_cs && mem_oe && oe_cnt1 >= 1) ? ram1[mem_addr] : {DW{1'bz}};
  assign mem_data3 = (mem_cs3 && mem_oe3 && oe_cnt3 >= 3) ? ram3[mem_addr3] : {DW{1'bz}};

  always @(posedge clk) begin
    oe_cnt1 <= (mem_cs && mem_oe) ? oe_cnt1 + 1 : 0;
    oe_cnt3 <= (mem_cs3 && mem_oe3) ? oe_cnt3 + 1 : 0;
    if (mem_cs && mem_we) ram1[mem_addr] <= mem_data;
    if (mem_cs3 && mem_we3) ram3[mem_addr3] <= mem_data3;
  end

  logic [AW-1:0] cur_addr = '0;
  logic [DW-1:0] cur_wdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst_n) begin
      chk("bus_we_oe_mutex", 32'(mem_we && mem_oe), 32'(0));
      chk("bus_we_oe_mutex3", 32'(mem_we3 && mem_oe3), 32'(0));
      chk("cs_decode", 32'(mem_cs), 32'(mem_we || mem_oe));
      if (mem_we) begin
        chk("wr_bus_data", 32'(mem_data), 32'(cur_wdata));
        chk("wr_bus_addr", 32'(mem_addr), 32'(cur_addr));
      end
      if (mem_oe) chk("rd_bus_addr", 32'(mem_addr), 32'(cur_addr));
    end
  endtask

  task automatic txn1(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input int hold, output logic got_we, output logic [DW-1:0] got_rd,
                      output int lat);
    int k;
    k = 0;
    while (!req_ready && k < 50) begin tick(); k++; end
    chk("req_ready_idle", 32'(req_ready), 32'(1));
    cur_addr = a; cur_wdata = d;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; rsp_ready = (hold == 0);
    tick();
    chk("req_ready_busy", 32'(req_ready), 32'(0));
    k = 0;
    // Garbage on the request port while busy must be ignored.
    while (!rsp_valid && k < 50) begin
      req_valid = 1'($urandom); req_we = 1'($urandom);
      req_addr = AW'($urandom); req_wdata = DW'($urandom);
      tick(); k++;
    end
    chk("rsp_valid_timeout", 32'(rsp_valid), 32'(1));
    lat = k + 1;
    got_we = rsp_we; got_rd = rsp_rdata;
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("bp_rsp_valid", 32'(rsp_valid), 32'(1));
      chk("bp_rdata_stable", 32'(rsp_rdata), 32'(got_rd));
      chk("bp_rsp_we_stable", 32'(rsp_we), 32'(got_we));
      chk("bp_req_ready", 32'(req_ready), 32'(0));
    end
    rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("rsp_valid_after_hs", 32'(rsp_valid), 32'(0));
    chk("req_ready_after_hs", 32'(req_ready), 32'(1));
  endtask

  task automatic txn3(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output logic got_we, output logic [DW-1:0] got_rd, output int lat);
    int k;
    k = 0;
    while (!req_ready3 && k < 50) begin tick(); k++; end
    req_valid3 = 1'b1; req_we3 = we; req_addr3 = a; req_wdata3 = d; rsp_ready3 = 1'b1;
    tick();
    req_valid3 = 1'b0;
    k = 0;
    while (!rsp_valid3 && k < 50) begin tick(); k++; end
    chk("rsp3_timeout", 32'(rsp_valid3), 32'(1));
    lat = k + 1;
    got_we = rsp_we3; got_rd = rsp_rdata3;
    tick();
    chk("req_ready3_after_hs", 32'(req_ready3), 32'(1));
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          exp_we;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t vecs[12];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [AW-1:0] written[$];

  initial begin
    logic          gw, we;
    logic [DW-1:0] gr, d, exp_rd;
    logic [AW-1:0] a;
    int            lat, hold;

    vecs[0]  = '{1'b1, 14'h0005, 16'hBEEF, 1'b1, 16'h0000};
    vecs[1]  = '{1'b0, 14'h0005, 16'h0000, 1'b0, 16'hBEEF};
    vecs[2]  = '{1'b1, 14'h0001, 16'h1111, 1'b1, 16'h0000};
    vecs[3]  = '{1'b1, 14'h1001, 16'h2222, 1'b1, 16'h0000};
    vecs[4]  = '{1'b1, 14'h2001, 16'h3333, 1'b1, 16'h0000};
    vecs[5]  = '{1'b1, 14'h3001, 16'h4444, 1'b1, 16'h0000};
    vecs[6]  = '{1'b0, 14'h0001, 16'h0000, 1'b0, 16'h1111};
    vecs[7]  = '{1'b0, 14'h1001, 16'h0000, 1'b0, 16'h2222};
    vecs[8]  = '{1'b0, 14'h2001, 16'h0000, 1'b0, 16'h3333};
    vecs[9]  = '{1'b0, 14'h3001, 16'h0000, 1'b0, 16'h4444};
    vecs[10] = '{1'b1, 14'h3FFF, 16'h8001, 1'b1, 16'h0000};
    vecs[11] = '{1'b0, 14'h3FFF, 16'h0000, 1'b0, 16'h8001};

    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; rsp_ready = 0;
    req_valid3 = 0; req_we3 = 0; req_addr3 = '0; req_wdata3 = '0; rsp_ready3 = 0;

    #2;
    chk("rst_req_ready", 32'(req_ready), 32'(1));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_mem_strobes", 32'({mem_cs, mem_we, mem_oe}), 32'(0));
    chk("rst_mem_addr", 32'(mem_addr), 32'(0));
    chk("rst_rsp_data", 32'({rsp_we, rsp_rdata}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      txn1(vecs[i].we, vecs[i].addr, vecs[i].wdata, 0, gw, gr, lat);
      chk($sformatf("vec%0d_rsp_we", i), 32'(gw), 32'(vecs[i].exp_we));
      chk($sformatf("vec%0d_rdata", i), 32'(gr), 32'(vecs[i].exp_rd));
      chk($sformatf("vec%0d_latency", i), 32'(lat), vecs[i].we ? 32'(2) : 32'(3));
      if (vecs[i].we) begin
        ref_mem[vecs[i].addr] = vecs[i].wdata;
        written.push_back(vecs[i].addr);
      end
    end

    // Backpressure: read held 5 cycles.
    txn1(1'b0, 14'h1001, 16'h0000, 5, gw, gr, lat);
    chk("bp_final_rdata", 32'(gr), 32'(16'h2222));
    chk("bp_final_rsp_we", 32'(gw), 32'(0));

    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom);
      d  = DW'($urandom);
      if (we) a = AW'($urandom);
      else    a = written[$urandom_range(0, written.size() - 1)];
      hold = $urandom_range(0, 3);
      txn1(we, a, d, hold, gw, gr, lat);
      exp_rd = we ? 16'h0000 : ref_mem[a];
      if (we) begin
        ref_mem[a] = d;
        written.push_back(a);
      end
      chk($sformatf("rnd%0d_rsp_we", i), 32'(gw), 32'(we));
      chk($sformatf("rnd%0d_rdata", i), 32'(gr), 32'(exp_rd));
      chk($sformatf("rnd%0d_latency", i), 32'(lat), we ? 32'(2) : 32'(3));
    end

    // RD_LAT=3 instance: writes then back-to-back reads.
    txn3(1'b1, 14'h0100, 16'hA5A5, gw, gr, lat);
    chk("l3_wr_latency", 32'(lat), 32'(2));
    chk("l3_wr_ack", 32'({gw, gr}), 32'({1'b1, 16'h0000}));
    txn3(1'b1, 14'h2F00, 16'h5A5A, gw, gr, lat);
    txn3(1'b0, 14'h0100, 16'h0000, gw, gr, lat);
    chk("l3_rd1_latency", 32'(lat), 32'(5));
    chk("l3_rd1_data", 32'({gw, gr}), 32'({1'b0, 16'hA5A5}));
    txn3(1'b0, 14'h2F00, 16'h0000, gw, gr, lat);
    chk("l3_rd2_latency", 32'(lat), 32'(5));
    chk("l3_rd2_data", 32'({gw, gr}), 32'({1'b0, 16'h5A5A}));

    // Reset asserted in the middle of a read.
    cur_addr = 14'h0005;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 14'h0005; rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("mid_rd_oe", 32'({mem_cs, mem_oe}), 32'(2'b11));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_req_ready", 32'(req_ready), 32'(1));
    chk("arst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("arst_mem_strobes", 32'({mem_cs, mem_we, mem_oe}), 32'(0));
    chk("arst_mem_addr", 32'(mem_addr), 32'(0));
    chk("arst_rsp_data", 32'({rsp_we, rsp_rdata}), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_req_ready", 32'(req_ready), 32'(1));
      chk("post_rst_no_rsp", 32'(rsp_valid), 32'(0));
    end
    txn1(1'b0, 14'h0005, 16'h0000, 0, gw, gr, lat);
    chk("post_rst_read", 32'(gr), 32'(ref_mem[14'h0005]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
